axi_ar_fwd_allocator: RTL and testbench

- Forward read-address allocator for one initiator (slave-side) port of the AXI node.
- Round-robin arbitrates AR requests from N_TARG_PORT target ports onto the single AR channel toward the slave.
- Prepends the winning port index to ARID so the backward read path can route R beats back to their source.
- Registered output stage, plus an outstanding-burst limiter fed by completion pulses from the read-response path.

---
 rtl/axi_ar_fwd_allocator.sv | 162 ++++++++++++++++
 tb/tb_axi_ar_fwd_allocator.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ar_fwd_allocator.sv
// Forward read-address allocator for one initiator port of the AXI node.
// Round-robin arbitrates AR requests from N_TARG_PORT target ports onto a
// single registered AR channel toward the slave. The winning port index is
// prepended to ARID so the read-response path can route R beats back.
// An outstanding-burst counter, decremented by rdone_i, throttles new grants.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ar*_i, arvalid_i  per-port AR requests (packed [port][field])
//   arready_o         per-port accept, at most one bit set
//   ar*_o, arvalid_o  registered AR toward the slave, arid_o = {port, arid}
//   arready_i         slave ready
//   rdone_i           one pulse per completed read burst
//   outstanding_o     any burst in flight
//   full_o            outstanding count reached MAX_OUTST
module axi_ar_fwd_allocator #(
   parameter int AXI_ADDR_W  = 32,
   parameter int AXI_USER_W  = 6,
   parameter int AXI_ID_IN   = 16,
   parameter int N_TARG_PORT = 4,
   parameter int LOG_N_TARG  = $clog2(N_TARG_PORT),
   parameter int AXI_ID_OUT  = AXI_ID_IN + LOG_N_TARG,
   parameter int MAX_OUTST   = 15
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [N_TARG_PORT-1:0][AXI_ID_IN-1:0]  arid_i,
   input  logic [N_TARG_PORT-1:0][AXI_ADDR_W-1:0] araddr_i,
   input  logic [N_TARG_PORT-1:0][7:0]            arlen_i,
   input  logic [N_TARG_PORT-1:0][2:0]            arsize_i,
   input  logic [N_TARG_PORT-1:0][1:0]            arburst_i,
   input  logic [N_TARG_PORT-1:0][AXI_USER_W-1:0] aruser_i,
   input  logic [N_TARG_PORT-1:0]                 arvalid_i,
   output logic [N_TARG_PORT-1:0]                 arready_o,
   output logic [AXI_ID_OUT-1:0]                  arid_o,
   output logic [AXI_ADDR_W-1:0]                  araddr_o,
   output logic [7:0]                             arlen_o,
   output logic [2:0]                             arsize_o,
   output logic [1:0]                             arburst_o,
   output logic [AXI_USER_W-1:0]                  aruser_o,
   output logic                                   arvalid_o,
   input  logic                                   arready_i,
   input  logic                                   rdone_i,
   output logic                                   outstanding_o,
   output logic                                   full_o
);

   localparam int CW = 10;

   logic                  arvalid_q, arvalid_d;
   logic [AXI_ID_OUT-1:0] arid_q, arid_d;
   logic [AXI_ADDR_W-1:0] araddr_q, araddr_d;
   logic [7:0]            arlen_q, arlen_d;
   logic [2:0]            arsize_q, arsize_d;
   logic [1:0]            arburst_q, arburst_d;
   logic [AXI_USER_W-1:0] aruser_q, aruser_d;
   logic [LOG_N_TARG-1:0] ptr_q, ptr_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   logic                  found;
   logic [LOG_N_TARG-1:0] gnt_idx;
   logic                  can_load, load;

   // Round-robin search starting one past the last winner, wrapping modulo
   // N_TARG_PORT (which need not be a power of two).
   always_comb begin
      logic [LOG_N_TARG:0] sum;
      sum     = '0;
      found   = 1'b0;
      gnt_idx = '0;
      for (int i = 1; i <= N_TARG_PORT; i++) begin
         sum = {1'b0, ptr_q} + (LOG_N_TARG+1)'(i);
         if (sum >= (LOG_N_TARG+1)'(N_TARG_PORT))
            sum = sum - (LOG_N_TARG+1)'(N_TARG_PORT);
         if (!found && arvalid_i[sum[LOG_N_TARG-1:0]]) begin
            found   = 1'b1;
            gnt_idx = sum[LOG_N_TARG-1:0];
         end
      end
   end

   assign full_o        = (cnt_q == CW'(MAX_OUTST));
   assign outstanding_o = (cnt_q != '0);
   assign can_load      = (!arvalid_q || arready_i) && !full_o;
   assign load          = can_load && found;
   assign arready_o     = load ? (N_TARG_PORT'(1) << gnt_idx) : '0;

   always_comb begin
      arvalid_d = arvalid_q;
      arid_d    = arid_q;
      araddr_d  = araddr_q;
      arlen_d   = arlen_q;
      arsize_d  = arsize_q;
      arburst_d = arburst_q;
      aruser_d  = aruser_q;
      ptr_d     = ptr_q;
      if (load) begin
         arvalid_d = 1'b1;
         arid_d    = {gnt_idx, arid_i[gnt_idx]};
         araddr_d  = araddr_i[gnt_idx];
         arlen_d   = arlen_i[gnt_idx];
         arsize_d  = arsize_i[gnt_idx];
         arburst_d = arburst_i[gnt_idx];
         aruser_d  = aruser_i[gnt_idx];
         ptr_d     = gnt_idx;
      end else if (arready_i) begin
         // accepted (or already empty) and nothing new to load
         arvalid_d = 1'b0;
      end
   end

   // Issue and completion in the same cycle cancel; completion at zero saturates.
   always_comb begin
      cnt_d = cnt_q;
      if (load && !rdone_i)
         cnt_d = cnt_q + CW'(1);
      else if (!load && rdone_i && cnt_q != '0)
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arvalid_q <= 1'b0;
         arid_q    <= '0;
         araddr_q  <= '0;
         arlen_q   <= '0;
         arsize_q  <= '0;
         arburst_q <= '0;
         aruser_q  <= '0;
         ptr_q     <= LOG_N_TARG'(N_TARG_PORT-1);
         cnt_q     <= '0;
      end else begin
         arvalid_q <= arvalid_d;
         arid_q    <= arid_d;
         araddr_q  <= araddr_d;
         arlen_q   <= arlen_d;
         arsize_q  <= arsize_d;
         arburst_q <= arburst_d;
         aruser_q  <= aruser_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
      end
   end

   assign arvalid_o = arvalid_q;
   assign arid_o    = arid_q;
   assign araddr_o  = araddr_q;
   assign arlen_o   = arlen_q;
   assign arsize_o  = arsize_q;
   assign arburst_o = arburst_q;
   assign aruser_o  = aruser_q;

`ifndef SYNTHESIS
   // A requester must hold arvalid until its handshake; this block does not
   // recover from a withdrawn request.
   for (genvar p = 0; p < N_TARG_PORT; p++) begin : g_hold_chk
      a_hold: assert property (@(posedge clk) disable iff (!rst_n)
         (arvalid_i[p] && !arready_o[p]) |=> arvalid_i[p]);
   end
`endif

endmodule

// File: tb/tb_axi_ar_fwd_allocator.sv
module tb_axi_ar_fwd_allocator;
   localparam int AW = 32, UW = 6, IW = 16, NP = 4, LG = 2, OW = 18, MO = 2;

   logic clk = 1'b0, rst_n = 1'b0;
   logic [NP-1:0][IW-1:0] arid_i;
   logic [NP-1:0][AW-1:0] araddr_i;
   logic [NP-1:0][7:0]    arlen_i;
   logic [NP-1:0][2:0]    arsize_i;
   logic [NP-1:0][1:0]    arburst_i;
   logic [NP-1:0][UW-1:0] aruser_i;
   logic [NP-1:0]         arvalid_i, arready_o;
   logic [OW-1:0]         arid_o;
   logic [AW-1:0]         araddr_o;
   logic [7:0]            arlen_o;
   logic [2:0]            arsize_o;
   logic [1:0]            arburst_o;
   logic [UW-1:0]         aruser_o;
   logic                  arvalid_o, arready_i, rdone_i, outstanding_o, full_o;

   typedef struct packed {
      logic [OW-1:0] id;
      logic [AW-1:0] addr;
      logic [7:0]    len;
      logic [2:0]    size;
      logic [1:0]    burst;
      logic [UW-1:0] user;
   } exp_t;
   exp_t exp_q[$];
   int n_tests = 0, n_fail = 0;

   axi_ar_fwd_allocator #(.AXI_ADDR_W(AW), .AXI_USER_W(UW), .AXI_ID_IN(IW),
      .N_TARG_PORT(NP), .MAX_OUTST(MO)) dut (
      .clk(clk), .rst_n(rst_n), .arid_i(arid_i), .araddr_i(araddr_i),
      .arlen_i(arlen_i), .arsize_i(arsize_i), .arburst_i(arburst_i),
      .aruser_i(aruser_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
      .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o),
      .arsize_o(arsize_o), .arburst_o(arburst_o), .aruser_o(aruser_o),
      .arvalid_o(arvalid_o), .arready_i(arready_i), .rdone_i(rdone_i),
      .outstanding_o(outstanding_o), .full_o(full_o));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   // Scoreboard: every output handshake must match the oldest expected burst.
   always @(negedge clk) begin
      exp_t e, got;
      if (rst_n && arvalid_o && arready_i) begin
         got = {arid_o, araddr_o, arlen_o, arsize_o, arburst_o, aruser_o};
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got burst %h, required none", got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               n_fail++;
               $display("FAIL sb_payload: got %h required %h", got, e);
            end
         end
      end
   end

   task set_port(input int p, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                 input logic [7:0] len);
      arid_i[p]    = id;
      araddr_i[p]  = addr;
      arlen_i[p]   = len;
      arsize_i[p]  = 3'(p + 1);
      arburst_i[p] = 2'(p % 3);
      aruser_i[p]  = 6'(p * 5 + 1);
   endtask

   task push_exp(input int p);
      exp_t e;
      e.id    = {2'(p), arid_i[p]};
      e.addr  = araddr_i[p];
      e.len   = arlen_i[p];
      e.size  = arsize_i[p];
      e.burst = arburst_i[p];
      e.user  = aruser_i[p];
      exp_q.push_back(e);
   endtask

   // Reset asserted immediately, inputs dropped while in reset.
   task do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      arvalid_i = '0; arready_i = 1'b0; rdone_i = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task test_reset();
      @(negedge clk);
      n_tests++;
      if ({arvalid_o, arready_o, outstanding_o, full_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_ctl: got v=%b rdy=%b out=%b full=%b required 0",
                  arvalid_o, arready_o, outstanding_o, full_o);
      end
      n_tests++;
      if ({arid_o, araddr_o, arlen_o, arsize_o, arburst_o, aruser_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_payload: got id=%h addr=%h required 0", arid_o, araddr_o);
      end
      @(posedge clk); #1;
   endtask

   task test_single();
      set_port(2, 16'h00A5, 32'h1000, 8'd3);
      arready_i = 1'b1; arvalid_i = 4'b0100;
      @(negedge clk);
      n_tests++;
      if (arready_o !== 4'b0100) begin
         n_fail++; $display("FAIL single_grant: got %b required 0100", arready_o);
      end
      push_exp(2);
      @(posedge clk); #1; arvalid_i = '0;
      @(negedge clk);
      n_tests++;
      if (arvalid_o !== 1'b1 || arid_o !== 18'h200A5 || araddr_o !== 32'h1000 || arlen_o !== 8'd3) begin
         n_fail++;
         $display("FAIL single_out: got v=%b id=%h addr=%h len=%0d required 1/200a5/1000/3",
                  arvalid_o, arid_o, araddr_o, arlen_o);
      end
      n_tests++;
      if (outstanding_o !== 1'b1 || full_o !== 1'b0) begin
         n_fail++; $display("FAIL single_cnt: got out=%b full=%b required 1/0", outstanding_o, full_o);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_tests++;
      if (arvalid_o !== 1'b0) begin
         n_fail++; $display("FAIL single_clear: got arvalid_o=%b required 0", arvalid_o);
      end
      @(posedge clk); #1;
      do_reset();
   endtask

   task test_fairness();
      int order[6] = '{0, 1, 2, 3, 0, 1};
      logic [3:0] expv;
      for (int p = 0; p < NP; p++) set_port(p, 16'h1100 + 16'(p), 32'h2000 + 32'(p * 16), 8'(p));
      rdone_i = 1'b1; arready_i = 1'b1; arvalid_i = 4'hF;
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         if (k < 6) begin
            expv = 4'b0001 << order[k];
            n_tests++;
            if (arready_o !== expv) begin
               n_fail++; $display("FAIL fair_grant%0d: got %b required %b", k, arready_o, expv);
            end
            push_exp(order[k]);
         end
         if (k >= 1) begin
            n_tests++;
            if (arvalid_o !== 1'b1) begin
               n_fail++; $display("FAIL fair_valid%0d: got %b required 1", k, arvalid_o);
            end
         end
         @(posedge clk); #1;
      end
      do_reset();
   endtask

   task test_backpressure();
      set_port(1, 16'h0111, 32'h3100, 8'd1);
      set_port(3, 16'h0333, 32'h3300, 8'd7);
      arready_i = 1'b1; arvalid_i = 4'b0010;
      @(negedge clk);
      n_tests++;
      if (arready_o !== 4'b0010) begin
         n_fail++; $display("FAIL bp_first: got %b required 0010", arready_o);
      end
      push_exp(1);
      @(posedge clk); #1; arready_i = 1'b0; arvalid_i = 4'b1010;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_tests++;
         if (arvalid_o !== 1'b1 || arready_o !== 4'b0000 || arid_o !== {2'd1, 16'h0111} || araddr_o !== 32'h3100) begin
            n_fail++;
            $display("FAIL bp_hold%0d: got v=%b rdy=%b id=%h addr=%h required 1/0000/10111/3100",
                     k, arvalid_o, arready_o, arid_o, araddr_o);
         end
         @(posedge clk); #1;
      end
      arready_i = 1'b1;
      @(negedge clk);
      n_tests++;
      if (arready_o !== 4'b1000) begin
         n_fail++; $display("FAIL bp_next: got %b required 1000", arready_o);
      end
      push_exp(3);
      @(posedge clk); #1; arvalid_i = 4'b0010;
      @(negedge clk);
      n_tests++;
      if (arvalid_o !== 1'b1 || arid_o !== {2'd3, 16'h0333} || full_o !== 1'b1 || arready_o !== 4'b0000) begin
         n_fail++;
         $display("FAIL bp_out3: got v=%b id=%h full=%b rdy=%b required 1/30333/1/0000",
                  arvalid_o, arid_o, full_o, arready_o);
      end
      @(posedge clk); #1;
      do_reset();
   endtask

   task test_throttle();
      for (int p = 0; p < 3; p++) set_port(p, 16'h0400 + 16'(p), 32'h4000 + 32'(p * 256), 8'(p + 2));
      arready_i = 1'b1; rdone_i = 1'b0; arvalid_i = 4'b0111;
      @(negedge clk);
      n_tests++;
      if (arready_o !== 4'b0001) begin
         n_fail++; $display("FAIL thr_g0: got %b required 0001", arready_o);
      end
      push_exp(0);
      @(posedge clk); #1; arvalid_i = 4'b0110;
      @(negedge clk);
      n_tests++;
      if (arready_o !== 4'b0010 || full_o !== 1'b0) begin
         n_fail++; $display("FAIL thr_g1: got rdy=%b full=%b required 0010/0", arready_o, full_o);
      end
      push_exp(1);
      @(posedge clk); #1; arvalid_i = 4'b0100;
      @(negedge clk);
      n_tests++;
      if (full_o !== 1'b1 || arready_o !== 4'b0000 || arvalid_o !== 1'b1) begin
         n_fail++; $display("FAIL thr_full: got full=%b rdy=%b v=%b required 1/0000/1", full_o, arready_o, arvalid_o);
      end
      @(posedge clk); #1; rdone_i = 1'b1;
      @(negedge clk);
      n_tests++;
      if (arvalid_o !== 1'b0 || full_o !== 1'b1 || arready_o !== 4'b0000) begin
         n_fail++;
         $display("FAIL thr_rdone_same: got v=%b full=%b rdy=%b required 0/1/0000", arvalid_o, full_o, arready_o);
      end
      @(posedge clk); #1; rdone_i = 1'b0;
      @(negedge clk);
      n_tests++;
      if (full_o !== 1'b0 || arready_o !== 4'b0100) begin
         n_fail++; $display("FAIL thr_free: got full=%b rdy=%b required 0/0100", full_o, arready_o);
      end
      push_exp(2);
      @(posedge clk); #1; arvalid_i = '0;
      @(negedge clk);
      n_tests++;
      if (arvalid_o !== 1'b1 || full_o !== 1'b1) begin
         n_fail++; $display("FAIL thr_refull: got v=%b full=%b required 1/1", arvalid_o, full_o);
      end
      @(posedge clk); #1;
      do_reset();
   endtask

   task test_simultaneous();
      for (int p = 0; p < 2; p++) set_port(p, 16'h0500 + 16'(p), 32'h5000 + 32'(p * 64), 8'(p));
      arready_i = 1'b1; rdone_i = 1'b0; arvalid_i = 4'b0001;
      @(negedge clk);
      n_tests++;
      if (arready_o !== 4'b0001) begin
         n_fail++; $display("FAIL sim_g0: got %b required 0001", arready_o);
      end
      push_exp(0);
      @(posedge clk); #1; arvalid_i = 4'b0010; rdone_i = 1'b1;
      @(negedge clk);
      n_tests++;
      if (arready_o !== 4'b0010) begin
         n_fail++; $display("FAIL sim_g1: got %b required 0010", arready_o);
      end
      push_exp(1);
      @(posedge clk); #1; arvalid_i = '0; rdone_i = 1'b0;
      @(negedge clk);
      n_tests++;
      if (outstanding_o !== 1'b1 || full_o !== 1'b0) begin
         n_fail++; $display("FAIL sim_cancel: got out=%b full=%b required 1/0", outstanding_o, full_o);
      end
      @(posedge clk); #1; rdone_i = 1'b1;
      @(posedge clk); #1; rdone_i = 1'b1;
      @(negedge clk);
      n_tests++;
      if (outstanding_o !== 1'b0) begin
         n_fail++; $display("FAIL sim_dec: got out=%b required 0", outstanding_o);
      end
      @(posedge clk); #1; rdone_i = 1'b0; arvalid_i = 4'b0001;
      @(negedge clk);
      n_tests++;
      if (outstanding_o !== 1'b0 || arready_o !== 4'b0001) begin
         n_fail++; $display("FAIL sim_sat: got out=%b rdy=%b required 0/0001", outstanding_o, arready_o);
      end
      push_exp(0);
      @(posedge clk); #1; arvalid_i = 4'b0010;
      @(negedge clk);
      n_tests++;
      if (outstanding_o !== 1'b1 || full_o !== 1'b0 || arready_o !== 4'b0010) begin
         n_fail++;
         $display("FAIL sim_one: got out=%b full=%b rdy=%b required 1/0/0010", outstanding_o, full_o, arready_o);
      end
      push_exp(1);
      @(posedge clk); #1; arvalid_i = '0;
      @(negedge clk);
      n_tests++;
      if (full_o !== 1'b1) begin
         n_fail++; $display("FAIL sim_two: got full=%b required 1", full_o);
      end
      @(posedge clk); #1;
      do_reset();
   endtask

   task test_reset_mid();
      set_port(0, 16'h0600, 32'h6000, 8'd4);
      set_port(2, 16'h0602, 32'h6200, 8'd5);
      set_port(3, 16'h0603, 32'h6300, 8'd6);
      arready_i = 1'b0; arvalid_i = 4'b0100;
      @(negedge clk);
      push_exp(2);
      @(posedge clk); #1; arvalid_i = '0;
      @(negedge clk);
      n_tests++;
      if (arvalid_o !== 1'b1) begin
         n_fail++; $display("FAIL rmid_pending: got arvalid_o=%b required 1", arvalid_o);
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if (arvalid_o !== 1'b0 || outstanding_o !== 1'b0 || arid_o !== '0) begin
         n_fail++;
         $display("FAIL rmid_async: got v=%b out=%b id=%h required 0/0/0", arvalid_o, outstanding_o, arid_o);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      exp_q.delete();
      rst_n = 1'b1; arready_i = 1'b1; arvalid_i = 4'b1001;
      @(negedge clk);
      n_tests++;
      if (arready_o !== 4'b0001) begin
         n_fail++; $display("FAIL rmid_prio: got %b required 0001", arready_o);
      end
      push_exp(0);
      @(posedge clk); #1; arvalid_i = 4'b1000;
      @(negedge clk);
      n_tests++;
      if (arready_o !== 4'b1000) begin
         n_fail++; $display("FAIL rmid_next: got %b required 1000", arready_o);
      end
      push_exp(3);
      @(posedge clk); #1; arvalid_i = '0;
      @(negedge clk);
      @(posedge clk); #1;
      do_reset();
   endtask

   initial begin
      arvalid_i = '0; arready_i = 1'b0; rdone_i = 1'b0;
      for (int p = 0; p < NP; p++) set_port(p, '0, '0, '0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_throttle();
      test_simultaneous();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
